formula_2_pipe_fifos_bp: RTL and testbench
==========================================

Name: formula_2_pipe_fifos_bp

Overview:
- Pipelined evaluator of res = isqrt(a + isqrt(b + isqrt(c))), generalised in pipeline depth and output buffering.
- Adds valid/ready back-pressure on both sides. The isqrt pipelines cannot stall, so a credit counter guarantees every accepted argument set has a reserved output-FIFO slot.
- Sits between an arbitrary producer and a consumer that may stall; drop-in successor of the unstalled formula-2 FIFO pipe.

Parameters:
- N, 4, pipe stages per isqrt instance (≥1); all three instances use n_pipe_stages = N.
- OUT_DEPTH, 3*N+2, output FIFO depth and credit limit (≥1). Values < 3N+2 are legal but reduce peak throughput.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- arg_vld  input  1  argument set valid
- arg_rdy  output  1  block can accept an argument set
- a  input  32  argument a
- b  input  32  argument b
- c  input  32  argument c
- res_vld  output  1  result valid (output FIFO not empty)
- res_rdy  input  1  consumer accepts result
- res  output  32  result, zero-extended from 16 bits
- stall_cnt  output  32  performance counter (see Optional Feature)

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- accept = arg_vld & arg_rdy; pop = res_vld & res_rdy.
- Exactly 3 isqrt instances, chained c -> (b + y_c) -> (a + y_bc).
- b is delayed in a flip-flop FIFO of depth N and a in one of depth 2N.
  - Both are pushed on accept.
  - b FIFO is popped on isqrt_c y_vld; a FIFO on isqrt_bc y_vld.
  - Neither may over- or underflow under any legal traffic.
- Sums are 32-bit, modulo 2^32 (carry discarded); the 16-bit isqrt output is zero-extended before each add.
- Final 16-bit isqrt result is pushed into an output flip-flop FIFO of depth OUT_DEPTH on isqrt_abc y_vld.
  - res is driven from the head entry, zero-extended to 32 bits.
  - res = 0 whenever res_vld = 0.
- Latency: accept in cycle t gives res_vld = 1 in cycle t+3N+1 if the output FIFO was empty. Results leave in acceptance order.
- Credit counter cnt, width clog2(OUT_DEPTH+1), counts in-flight sets plus output-FIFO occupancy:
  - accept & !pop: cnt+1
  - pop & !accept: cnt-1
  - both or neither: cnt unchanged
- arg_rdy = (cnt < OUT_DEPTH) & !rst. It is registered-state only and has no combinational path from res_rdy or arg_vld.
- Guarantee: output FIFO never overflows; a push from isqrt_abc always finds a free slot, including a simultaneous push and pop when the FIFO is full.
- With res_rdy held at 1 and OUT_DEPTH ≥ 3N+2, one result per cycle is sustained indefinitely and arg_rdy stays 1.
- Consumer stall: res_vld and res hold stable until pop. arg_rdy drops once cnt reaches OUT_DEPTH. In-flight data still drains into the FIFO.
- Reset (also mid-operation) in cycle r:
  - All in-flight and buffered data is discarded; cnt = 0; all FIFOs are empty.
  - In cycle r+1: res_vld = 0, res = 0, arg_rdy = 1, stall_cnt = 0.
  - isqrt valid pipelines are cleared by the same rst.
- arg_vld while arg_rdy = 0: the set is not accepted and a/b/c are ignored. The producer must hold it (standard valid/ready).

Optional Feature:
- Macro FORMULA_2_PIPE_FIFOS_BP_PERF_EN.
- Defined: stall_cnt increments each cycle with res_vld & !res_rdy, saturates at 0xFFFFFFFF, and is cleared by rst.
- Undefined: stall_cnt is tied to 0 and no counter logic is generated.
- Datapath behaviour is identical either way.

Test Plan:
- Single set, N=4, a=9, b=12, c=16, res_rdy=1 -> one res_vld pulse 13 cycles after accept, res = 3.
- Saturating carry: a=0, b=1, c=0xFFFFFFFF -> res = 16. Wrap: a=25, b=0xFFFFFFFF, c=1 -> (b+1) wraps to 0, res = 5.
- Back-to-back stream, 100 random sets, res_rdy=1, OUT_DEPTH=14 -> arg_rdy never drops; 100 results in order, matching the reference model, one per cycle.
- res_rdy=0 and arg_vld=1 continuously, OUT_DEPTH=14 -> exactly 14 sets accepted, then arg_rdy=0. After res_rdy=1, all 14 results are emitted in order with no loss or duplication. With the macro defined, stall_cnt equals the observed stall cycles.
- Random arg_vld/res_rdy toggling over 1000 cycles, OUT_DEPTH=3 -> output sequence equals the accepted sequence and no FIFO overflow/underflow occurs (assertions on internal FIFOs).
- rst asserted for 1 cycle with 6 sets in flight and 2 buffered -> next cycle res_vld=0, arg_rdy=1. No stale results appear afterwards; the next accepted set a=0, b=0, c=0 yields res = 0 after 3N+1 cycles.

Source files
------------

// File: rtl/formula_2_pipe_fifos_bp.sv
// Back-pressured pipeline for res = isqrt(a + isqrt(b + isqrt(c))) with a credit-guarded output FIFO.
// Define FORMULA_2_PIPE_FIFOS_BP_PERF_EN to enable the saturating consumer-stall counter on stall_cnt.

module formula_2_pipe_fifos_bp #(
    parameter int N         = 4,
    parameter int OUT_DEPTH = 3 * N + 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    output logic        arg_rdy,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        res_vld,
    input  logic        res_rdy,
    output logic [31:0] res,
    output logic [31:0] stall_cnt
);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic          w_accept;
    logic          w_pop;
    logic [CW-1:0] r_cnt;

    logic          w_y_c_vld, w_y_bc_vld, w_y_abc_vld;
    logic [15:0]   w_y_c, w_y_bc, w_y_abc;
    logic [31:0]   w_b_head, w_a_head;
    logic          w_b_empty, w_a_empty, w_out_empty;
    logic [31:0]   w_sum_bc, w_sum_abc;
    logic [15:0]   w_out_head;

    assign w_accept = arg_vld && arg_rdy;
    assign w_pop    = res_vld && res_rdy;

    // Credit = sets inside the isqrt chain + entries in the output FIFO, so an
    // accepted set always owns an output slot by the time it emerges.
    assign arg_rdy  = (r_cnt < CW'(OUT_DEPTH)) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_pop && !w_accept) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    formula_2_pipe_fifos_bp_isqrt #(.N(N)) u_isqrt_c (
        .clk     (clk),
        .rst     (rst),
        .i_x_vld (w_accept),
        .i_x     (c),
        .o_y_vld (w_y_c_vld),
        .o_y     (w_y_c)
    );

    formula_2_pipe_fifos_bp_fifo #(.W(32), .DEPTH(N)) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_din   (b),
        .i_pop   (w_y_c_vld),
        .o_dout  (w_b_head),
        .o_empty (w_b_empty)
    );

    assign w_sum_bc = w_b_head + {16'h0000, w_y_c};

    formula_2_pipe_fifos_bp_isqrt #(.N(N)) u_isqrt_bc (
        .clk     (clk),
        .rst     (rst),
        .i_x_vld (w_y_c_vld),
        .i_x     (w_sum_bc),
        .o_y_vld (w_y_bc_vld),
        .o_y     (w_y_bc)
    );

    formula_2_pipe_fifos_bp_fifo #(.W(32), .DEPTH(2 * N)) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_din   (a),
        .i_pop   (w_y_bc_vld),
        .o_dout  (w_a_head),
        .o_empty (w_a_empty)
    );

    assign w_sum_abc = w_a_head + {16'h0000, w_y_bc};

    formula_2_pipe_fifos_bp_isqrt #(.N(N)) u_isqrt_abc (
        .clk     (clk),
        .rst     (rst),
        .i_x_vld (w_y_bc_vld),
        .i_x     (w_sum_abc),
        .o_y_vld (w_y_abc_vld),
        .o_y     (w_y_abc)
    );

    formula_2_pipe_fifos_bp_fifo #(.W(16), .DEPTH(OUT_DEPTH)) u_fifo_out (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_y_abc_vld),
        .i_din   (w_y_abc),
        .i_pop   (w_pop),
        .o_dout  (w_out_head),
        .o_empty (w_out_empty)
    );

    assign res_vld = !w_out_empty;
    assign res     = res_vld ? {16'h0000, w_out_head} : 32'h0000_0000;

    a_b_no_underflow: assert property (@(posedge clk) disable iff (rst) !(w_y_c_vld && w_b_empty));
    a_a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(w_y_bc_vld && w_a_empty));

`ifdef FORMULA_2_PIPE_FIFOS_BP_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (res_vld && !res_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'h0000_0000;
`endif

endmodule

// Non-stallable restoring square root: 32-bit radicand, 16-bit root, latency N cycles.
module formula_2_pipe_fifos_bp_isqrt #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_x_vld,
    input  logic [31:0] i_x,
    output logic        o_y_vld,
    output logic [15:0] o_y
);
    logic [31:0] r_x   [N];
    logic [15:0] r_r   [N];
    logic [19:0] r_rem [N];
    logic        r_vld [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_stage
        // The 16 root-digit iterations are spread as evenly as possible over the stages.
        localparam int ITERS = ((gi + 1) * 16) / N - (gi * 16) / N;

        logic [31:0] w_x_in;
        logic [15:0] w_r_in;
        logic [19:0] w_rem_in;
        logic        w_vld_in;
        logic [31:0] w_x_out;
        logic [15:0] w_r_out;
        logic [19:0] w_rem_out;

        if (gi == 0) begin : g_head
            assign w_x_in   = i_x;
            assign w_r_in   = '0;
            assign w_rem_in = '0;
            assign w_vld_in = i_x_vld;
        end else begin : g_link
            assign w_x_in   = r_x[gi-1];
            assign w_r_in   = r_r[gi-1];
            assign w_rem_in = r_rem[gi-1];
            assign w_vld_in = r_vld[gi-1];
        end

        always_comb begin
            logic [31:0] v_x;
            logic [15:0] v_r;
            logic [19:0] v_rem;
            v_x   = w_x_in;
            v_r   = w_r_in;
            v_rem = w_rem_in;
            for (int j = 0; j < ITERS; j++) begin
                v_rem = {v_rem[17:0], v_x[31:30]};
                v_x   = {v_x[29:0], 2'b00};
                if (v_rem >= {2'b00, v_r, 2'b01}) begin
                    v_rem = v_rem - {2'b00, v_r, 2'b01};
                    v_r   = {v_r[14:0], 1'b1};
                end else begin
                    v_r   = {v_r[14:0], 1'b0};
                end
            end
            w_x_out   = v_x;
            w_r_out   = v_r;
            w_rem_out = v_rem;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld[gi] <= 1'b0;
            end else begin
                r_vld[gi] <= w_vld_in;
            end
            r_x[gi]   <= w_x_out;
            r_r[gi]   <= w_r_out;
            r_rem[gi] <= w_rem_out;
        end
    end

    assign o_y_vld = r_vld[N-1];
    assign o_y     = r_r[N-1];

endmodule

// Flip-flop FIFO with combinational head; a push into a full FIFO is legal only alongside a pop.
module formula_2_pipe_fifos_bp_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full && !i_pop));

endmodule

// File: tb/tb_formula_2_pipe_fifos_bp.sv
// Scoreboard bench for formula_2_pipe_fifos_bp: expected results queued on accept, compared on pop.
// Compile with FORMULA_2_PIPE_FIFOS_BP_PERF_EN defined to also track stall_cnt against a model.

module tb_formula_2_pipe_fifos_bp;
    localparam int N         = 4;
    localparam int OUT_DEPTH = 3 * N + 2;
    localparam int LAT       = 3 * N + 1;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        arg_vld = 1'b0;
    logic        res_rdy = 1'b0;
    logic [31:0] a = '0, b = '0, c = '0;
    logic        arg_rdy;
    logic        res_vld;
    logic [31:0] res;
    logic [31:0] stall_cnt;

    formula_2_pipe_fifos_bp #(.N(N), .OUT_DEPTH(OUT_DEPTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .arg_vld   (arg_vld),
        .arg_rdy   (arg_rdy),
        .a         (a),
        .b         (b),
        .c         (c),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .res       (res),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks     = 0;
    int          n_fail       = 0;
    int          cyc          = 0;
    int          pop_count    = 0;
    int          accept_count = 0;
    int          last_pop_cyc = 0;
    int          stall_model  = 0;
    logic [31:0] last_res     = '0;
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference root by greedy bit setting on 64-bit squares.
    function automatic logic [15:0] ref_isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        logic [63:0] sq;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            t  = r | (16'd1 << i);
            sq = 64'(t) * 64'(t);
            if (sq <= 64'(x)) r = t;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_formula(input logic [31:0] va, vb, vc);
        logic [31:0] s1, s2;
        s1 = vb + {16'h0, ref_isqrt(vc)};
        s2 = va + {16'h0, ref_isqrt(s1)};
        return {16'h0, ref_isqrt(s2)};
    endfunction

    // Inputs change just after posedge; on the negedge we see exactly what the next edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_model = 0;
        end else begin
            if (arg_vld && arg_rdy) begin
                exp_q.push_back(ref_formula(a, b, c));
                accept_count++;
            end
            if (res_vld && !res_rdy) stall_model++;
            if (res_vld && res_rdy) begin
                pop_count++;
                last_pop_cyc = cyc;
                last_res     = res;
                check_eq("res_expected_present", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("res", res, exp_q.pop_front());
            end else if (!res_vld) begin
                check_eq("res_idle_zero", res, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stall(input string tag);
`ifdef FORMULA_2_PIPE_FIFOS_BP_PERF_EN
        check_eq(tag, stall_cnt, 32'(stall_model));
`else
        check_eq(tag, stall_cnt, 32'd0);
`endif
    endtask

    // Called just after a posedge; returns just after a posedge with arg_vld low.
    task automatic send(input logic [31:0] va, vb, vc, output int acc_cyc, output int waits);
        arg_vld = 1'b1;
        a = va; b = vb; c = vc;
        waits   = 0;
        acc_cyc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (arg_rdy) begin
                acc_cyc = cyc;
                break;
            end
            waits++;
            tick();
        end
        check_eq("send_accepted", 32'(acc_cyc >= 0), 32'd1);
        tick();
        arg_vld = 1'b0;
    endtask

    task automatic expect_single(input string tag, input logic [31:0] exp_res, input int t_acc);
        int lat;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (res_vld) begin
                lat = cyc - t_acc;
                check_eq({tag, "_res"}, res, exp_res);
                break;
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(LAT));
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, 32'(res_vld), 32'd0);
        tick();
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 500; k++) begin
            if (exp_q.size() == 0 && !res_vld) break;
            tick();
        end
        check_eq("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded, required finish before 1000000", $time);
        $fatal(1);
    end

    initial begin
        int          t_acc, w, waits_total, t_last, pops0, acc0, pending;
        logic [31:0] held;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check_eq("rst_res_vld", 32'(res_vld), 32'd0);
        check_eq("rst_arg_rdy", 32'(arg_rdy), 32'd1);
        check_eq("rst_res", res, 32'd0);
        check_stall("rst_stall_cnt");

        res_rdy = 1'b1;
        send(32'd9, 32'd12, 32'd16, t_acc, w);
        expect_single("single", 32'd3, t_acc);

        send(32'd0, 32'd1, 32'hFFFF_FFFF, t_acc, w);
        wait_drain();
        check_eq("carry_res", last_res, 32'd16);
        send(32'd25, 32'hFFFF_FFFF, 32'd1, t_acc, w);
        wait_drain();
        check_eq("wrap_res", last_res, 32'd5);

        pops0 = pop_count;
        waits_total = 0;
        for (int i = 0; i < 100; i++) begin
            send($urandom, $urandom, (i % 4 == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 15) : $urandom,
                 t_last, w);
            waits_total += w;
        end
        check_eq("stream_rdy_drops", 32'(waits_total), 32'd0);
        wait_drain();
        check_eq("stream_count", 32'(pop_count - pops0), 32'd100);
        check_eq("stream_last_latency", 32'(last_pop_cyc - t_last), 32'(LAT));
        check_stall("stream_stall_cnt");

        res_rdy = 1'b0;
        acc0    = accept_count;
        arg_vld = 1'b1;
        a = $urandom; b = $urandom; c = $urandom;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            pending = arg_rdy ? 0 : 1;
            tick();
            if (pending == 0) begin
                a = $urandom; b = $urandom; c = $urandom;
            end
        end
        arg_vld = 1'b0;
        check_eq("fill_accepts", 32'(accept_count - acc0), 32'(OUT_DEPTH));
        check_eq("fill_arg_rdy_low", 32'(arg_rdy), 32'd0);
        check_eq("fill_res_vld", 32'(res_vld), 32'd1);
        held = res;
        repeat (3) tick();
        check_eq("fill_res_stable", res, held);
        check_stall("fill_stall_cnt");
        pops0   = pop_count;
        res_rdy = 1'b1;
        wait_drain();
        check_eq("fill_drain_count", 32'(pop_count - pops0), 32'(OUT_DEPTH));
        check_stall("fill_drain_stall_cnt");

        acc0    = accept_count;
        pops0   = pop_count;
        pending = 0;
        for (int k = 0; k < 1000; k++) begin
            if (pending == 0) begin
                arg_vld = ($urandom_range(0, 2) != 0);
                a = $urandom; b = $urandom; c = $urandom;
            end
            res_rdy = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            pending = (arg_vld && !arg_rdy) ? 1 : 0;
            tick();
        end
        arg_vld = 1'b0;
        check_stall("rand_stall_cnt");
        res_rdy = 1'b1;
        wait_drain();
        check_eq("rand_pop_vs_accept", 32'(pop_count - pops0), 32'(accept_count - acc0));

        res_rdy = 1'b0;
        for (int i = 0; i < 2; i++) send($urandom, $urandom, $urandom, t_acc, w);
        repeat (LAT + 2) tick();
        for (int i = 0; i < 6; i++) send($urandom, $urandom, $urandom, t_acc, w);
        pops0 = pop_count;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("mid_rst_res_vld", 32'(res_vld), 32'd0);
        check_eq("mid_rst_arg_rdy", 32'(arg_rdy), 32'd1);
        check_eq("mid_rst_res", res, 32'd0);
        check_stall("mid_rst_stall_cnt");
        res_rdy = 1'b1;
        repeat (3 * LAT) tick();
        check_eq("mid_rst_no_stale", 32'(pop_count - pops0), 32'd0);
        send(32'd0, 32'd0, 32'd0, t_acc, w);
        expect_single("post_rst", 32'd0, t_acc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
